// File: rtl/cache_controller.sv
// cache_controller
//   Direct-mapped, write-through, no-write-allocate cache in front of a
//   fixed-latency main memory. Each line holds a valid bit, a tag and 4 words.
//   Read hits complete in the request cycle. Read misses fetch the whole block
//   in MEM_LATENCY cycles, and the retried lookup then hits. Every store goes
//   to memory and takes MEM_LATENCY cycles. A cached copy is patched only if
//   the store hits.
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 asynchronous active-low reset
//   cpu_address         CPU word address
//   cpu_write_data      CPU store data
//   cpu_read_en         CPU load request, held until cpu_ready
//   cpu_write_en        CPU store request, held until cpu_ready (wins over read)
//   cpu_read_data       load result; zero unless cpu_ready
//   cpu_ready           request completes this cycle
//   mem_address         main-memory word address
//   mem_write_data      main-memory store data
//   mem_read_en         main-memory block read request
//   mem_write_en        main-memory word write request
//   mem_read_data_128   block returned by memory; word k at [k*WORD_LEN +: WORD_LEN]
//   hit_count           saturating read-hit counter
//   miss_count          saturating read-miss counter
module cache_controller #(
  parameter int ADDRESS_LEN = 15,
  parameter int WORD_LEN    = 32,
  parameter int INDEX_LEN   = 10,
  parameter int MEM_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDRESS_LEN-1:0]  cpu_address,
  input  logic [WORD_LEN-1:0]     cpu_write_data,
  input  logic                    cpu_read_en,
  input  logic                    cpu_write_en,
  output logic [WORD_LEN-1:0]     cpu_read_data,
  output logic                    cpu_ready,
  output logic [ADDRESS_LEN-1:0]  mem_address,
  output logic [WORD_LEN-1:0]     mem_write_data,
  output logic                    mem_read_en,
  output logic                    mem_write_en,
  input  logic [4*WORD_LEN-1:0]   mem_read_data_128,
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count
);

  localparam int TAG_LEN = ADDRESS_LEN - INDEX_LEN - 2;
  localparam int LINES   = 1 << INDEX_LEN;
  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, MEM_READ, MEM_WRITE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] lat_cnt_reg, lat_cnt_next;

  logic [LINES-1:0]    valid_reg;
  logic [TAG_LEN-1:0]  tag_mem [LINES];
  logic [WORD_LEN-1:0] line_words [4];

  logic [1:0]           offset;
  logic [INDEX_LEN-1:0] index;
  logic [TAG_LEN-1:0]   addr_tag;
  logic                 hit;
  logic                 lat_last;
  logic                 fill_en;
  logic                 wr_update;
  logic                 hit_inc;
  logic                 miss_inc;

  assign offset   = cpu_address[1:0];
  assign index    = cpu_address[INDEX_LEN+1:2];
  assign addr_tag = cpu_address[ADDRESS_LEN-1:INDEX_LEN+2];
  assign hit      = valid_reg[index] && (tag_mem[index] == addr_tag);
  assign lat_last = (lat_cnt_reg == LAT_LAST);

  // Fill happens on the final memory-read edge. A store patches the cache
  // only on its final edge and only when the line is already present.
  assign fill_en   = (state_reg == MEM_READ)  && lat_last;
  assign wr_update = (state_reg == MEM_WRITE) && lat_last && hit;

  // One word-wide array per block word lets a store touch a single word.
  // Reads are combinational because hits must answer in the request cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    logic [WORD_LEN-1:0] data_mem [LINES];

    always_ff @(posedge clk) begin
      if (fill_en)
        data_mem[index] <= mem_read_data_128[gi*WORD_LEN +: WORD_LEN];
      else if (wr_update && (offset == 2'(gi)))
        data_mem[index] <= cpu_write_data;
    end

    assign line_words[gi] = data_mem[index];
  end

  always_ff @(posedge clk) begin
    if (fill_en)
      tag_mem[index] <= addr_tag;
  end

  // Valid bits are the only cache state that is reset. Because an aborted
  // fill never reaches fill_en, a partial fill can never mark a line valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      valid_reg <= '0;
    else if (fill_en)
      valid_reg[index] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= 4'd0;
      hit_count   <= 16'd0;
      miss_count  <= 16'd0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
      if (hit_inc && (hit_count != 16'hFFFF))
        hit_count <= hit_count + 16'd1;
      if (miss_inc && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    lat_cnt_next   = lat_cnt_reg;
    cpu_ready      = 1'b0;
    cpu_read_data  = '0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (cpu_write_en) begin
          // A store wins even if a load is requested in the same cycle.
          state_next   = MEM_WRITE;
          lat_cnt_next = 4'd0;
        end else if (cpu_read_en) begin
          if (hit) begin
            cpu_ready     = 1'b1;
            cpu_read_data = line_words[offset];
            hit_inc       = 1'b1;
          end else begin
            miss_inc     = 1'b1;
            state_next   = MEM_READ;
            lat_cnt_next = 4'd0;
          end
        end
      end
      MEM_READ: begin
        mem_read_en = 1'b1;
        mem_address = {cpu_address[ADDRESS_LEN-1:2], 2'b00};
        if (lat_last) state_next = IDLE;
        else          lat_cnt_next = lat_cnt_reg + 4'd1;
      end
      MEM_WRITE: begin
        mem_write_en   = 1'b1;
        mem_address    = cpu_address;
        mem_write_data = cpu_write_data;
        if (lat_last) begin
          cpu_ready  = 1'b1;
          state_next = IDLE;
        end else begin
          lat_cnt_next = lat_cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] cpu_address;
  logic [31:0] cpu_write_data;
  logic        cpu_read_en;
  logic        cpu_write_en;
  logic [31:0] cpu_read_data;
  logic        cpu_ready;
  logic [14:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [127:0] mem_read_data_128;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: the word at address i holds the value i.
  assign mem_read_data_128 = {32'(mem_address) + 32'd3, 32'(mem_address) + 32'd2,
                              32'(mem_address) + 32'd1, 32'(mem_address)};

  cache_controller dut (
    .clk(clk), .rst(rst),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_read_data_128(mem_read_data_128),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Runs one request until cpu_ready; cycle 0 is the request cycle.
  // It only records observations. Each test task does its own comparisons.
  task automatic run_txn(input logic [14:0] addr, input logic [31:0] wdata,
                         input logic rd, input logic wr,
                         output int ready_cyc, output int rd_cyc, output int wr_cyc,
                         output logic [31:0] data, output logic [14:0] rd_addr,
                         output logic [14:0] wr_addr, output logic [31:0] wr_data,
                         output logic both, output logic stall_dirty);
    ready_cyc = -1; rd_cyc = 0; wr_cyc = 0; data = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; both = 1'b0; stall_dirty = 1'b0;
    @(negedge clk);
    cpu_address = addr; cpu_write_data = wdata; cpu_read_en = rd; cpu_write_en = wr;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (mem_read_en)  begin rd_cyc++; rd_addr = mem_address; end
      if (mem_write_en) begin wr_cyc++; wr_addr = mem_address; wr_data = mem_write_data; end
      if (mem_read_en && mem_write_en) both = 1'b1;
      if (!cpu_ready && cpu_read_data !== 32'd0) stall_dirty = 1'b1;
      if (cpu_ready) begin
        ready_cyc = c;
        data = cpu_read_data;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cpu_read_en = 1'b0; cpu_write_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cpu_address = 15'h0405; cpu_write_data = '0; cpu_read_en = 1'b1; cpu_write_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cpu_ready !== 1'b0 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0 ||
        cpu_read_data !== 32'd0 || mem_address !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rd=%b wr=%b data=%h maddr=%h, required all 0",
               cpu_ready, mem_read_en, mem_write_en, cpu_read_data, mem_address);
    end
    checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: hit=%0d miss=%0d, required 0 0", hit_count, miss_count);
    end
    $display("reset: outputs and counters sampled while rst low");
    cpu_read_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (cpu_ready !== 1'b0 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: ready=%b rd=%b wr=%b, required 0 0 0",
                 cpu_ready, mem_read_en, mem_write_en);
      end
    end
    $display("idle: no request for 3 cycles");
  endtask

  // Read request with the expected cycle of cpu_ready, count of memory-read
  // cycles, returned data and counter values after completion.
  task automatic test_read(input string name, input logic [14:0] addr,
                           input int exp_ready, input logic [31:0] exp_data,
                           input logic [15:0] exp_hit, input logic [15:0] exp_miss);
    int rc, rdc, wrc;
    logic [31:0] d, wd;
    logic [14:0] ra, wa;
    logic bo, sd;
    run_txn(addr, 32'd0, 1'b1, 1'b0, rc, rdc, wrc, d, ra, wa, wd, bo, sd);
    $display("read %s addr=%h ready_cycle=%0d data=%h hit=%0d miss=%0d",
             name, addr, rc, d, hit_count, miss_count);
    checks++;
    if (rc !== exp_ready) begin
      errors++;
      $display("FAIL %s_latency: ready at cycle %0d, required %0d", name, rc, exp_ready);
    end
    checks++;
    if (d !== exp_data) begin
      errors++;
      $display("FAIL %s_data: got %h, required %h", name, d, exp_data);
    end
    checks++;
    if (rdc !== (exp_ready == 0 ? 0 : exp_ready - 1) || wrc !== 0) begin
      errors++;
      $display("FAIL %s_mem_cycles: mem_read_en %0d cycles, mem_write_en %0d, required %0d and 0",
               name, rdc, wrc, (exp_ready == 0 ? 0 : exp_ready - 1));
    end
    if (exp_ready != 0) begin
      checks++;
      if (ra !== {addr[14:2], 2'b00}) begin
        errors++;
        $display("FAIL %s_mem_address: got %h, required %h", name, ra, {addr[14:2], 2'b00});
      end
    end
    checks++;
    if (sd !== 1'b0) begin
      errors++;
      $display("FAIL %s_stall_data: cpu_read_data nonzero while stalled, got 1 required 0", name);
    end
    checks++;
    if (hit_count !== exp_hit || miss_count !== exp_miss) begin
      errors++;
      $display("FAIL %s_counters: hit=%0d miss=%0d, required %0d %0d",
               name, hit_count, miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_write(input string name, input logic [14:0] addr,
                            input logic [31:0] wdata, input logic also_read);
    int rc, rdc, wrc;
    logic [31:0] d, wd;
    logic [14:0] ra, wa;
    logic bo, sd;
    run_txn(addr, wdata, also_read, 1'b1, rc, rdc, wrc, d, ra, wa, wd, bo, sd);
    $display("write %s addr=%h data=%h ready_cycle=%0d write_cycles=%0d",
             name, addr, wdata, rc, wrc);
    checks++;
    if (rc !== 4 || wrc !== 4) begin
      errors++;
      $display("FAIL %s_timing: ready cycle %0d, write cycles %0d, required 4 and 4",
               name, rc, wrc);
    end
    checks++;
    if (rdc !== 0 || bo !== 1'b0) begin
      errors++;
      $display("FAIL %s_no_read: mem_read_en cycles %0d overlap %b, required 0 0", name, rdc, bo);
    end
    checks++;
    if (wa !== addr || wd !== wdata) begin
      errors++;
      $display("FAIL %s_mem_bus: addr=%h data=%h, required %h %h", name, wa, wd, addr, wdata);
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    cpu_address = 15'h0800; cpu_read_en = 1'b1;
    @(negedge clk); // MEM_READ cycle 1
    @(negedge clk); #1; // MEM_READ cycle 2
    checks++;
    if (mem_read_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: mem_read_en=%b, required 1", mem_read_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_read_en !== 1'b0 || mem_address !== 15'd0 || cpu_ready !== 1'b0 ||
        hit_count !== 16'd0 || miss_count !== 16'd0) begin
      errors++;
      $display("FAIL abort_outputs: rd=%b maddr=%h ready=%b hit=%0d miss=%0d, required all 0",
               mem_read_en, mem_address, cpu_ready, hit_count, miss_count);
    end
    $display("abort: rst asserted in MEM_READ cycle 2");
    cpu_read_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read("miss_0405", 15'h0405, 5, 32'h405, 16'd1, 16'd1);
    test_read("hit_0406", 15'h0406, 0, 32'h406, 16'd2, 16'd1);
    test_read("conflict_1405", 15'h1405, 5, 32'h1405, 16'd3, 16'd2);
    test_read("evicted_0405", 15'h0405, 5, 32'h405, 16'd4, 16'd3);
    test_read("reload_1405", 15'h1405, 5, 32'h1405, 16'd5, 16'd4);
    test_write("hit_1405", 15'h1405, 32'hDEADBEEF, 1'b0);
    test_read("after_write_1405", 15'h1405, 0, 32'hDEADBEEF, 16'd6, 16'd4);
    test_write("miss_2000", 15'h2000, 32'hCAFEF00D, 1'b0);
    test_read("no_alloc_2000", 15'h2000, 5, 32'h2000, 16'd7, 16'd5);
    test_write("both_1406", 15'h1406, 32'h12345678, 1'b1);
    test_read("after_both_1406", 15'h1406, 0, 32'h12345678, 16'd8, 16'd5);
    test_reset_abort();
    test_read("after_abort_0800", 15'h0800, 5, 32'h800, 16'd1, 16'd1);
    test_read("invalidated_1406", 15'h1406, 5, 32'h1406, 16'd2, 16'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
